// File: rtl/aes_ctr_stream.sv
// Streaming AES-128 engine for ECB/CTR jobs, with an iterative round-per-cycle core.
// Bit 127 of every 128-bit bus is the MSB of byte 0.

module aes_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_in,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic         done,
    output logic [127:0] text_out
);

    logic [127:0] st;
    logic [127:0] rk;
    logic [7:0]   rcon;
    logic [3:0]   rnd;
    logic         run;
    logic [127:0] rk_next;
    logic [127:0] st_next;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        inv  = gmul(gmul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[4*c+rr] = b[4*((c+rr)%4)+rr];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c+1];
                a2 = t[4*c+2];
                a3 = t[4*c+3];
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    always_comb begin
        rk_next = expand_key(rk, rcon);
        st_next = aes_round(st, rk_next, rnd == 4'd10);
    end

    // Round keys are expanded on the fly, one round per cycle; done is a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= '0;
            rk       <= '0;
            rcon     <= 8'h00;
            rnd      <= 4'd0;
            run      <= 1'b0;
            done     <= 1'b0;
            text_out <= '0;
        end else begin
            done <= 1'b0;
            if (ld_in) begin
                st   <= text_in ^ key;
                rk   <= key;
                rcon <= 8'h01;
                rnd  <= 4'd1;
                run  <= 1'b1;
            end else if (run) begin
                st   <= st_next;
                rk   <= rk_next;
                rcon <= xtime(rcon);
                rnd  <= rnd + 4'd1;
                if (rnd == 4'd10) begin
                    run      <= 1'b0;
                    done     <= 1'b1;
                    text_out <= st_next;
                end
            end
        end
    end

endmodule

module aes_ctr_stream #(
    parameter int CTR_W     = 32,
    parameter int OUT_DEPTH = 4,
    parameter int NBLK_W    = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [NBLK_W-1:0] nblocks,
    input  logic [127:0]      key,
    input  logic [127:0]      iv,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic              busy,
    output logic              done
);

    localparam int           PTR_W    = $clog2(OUT_DEPTH);
    localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIN} state_t;

    state_t            state, state_next;
    logic              mode_q;
    logic [NBLK_W-1:0] remaining;
    logic [127:0]      key_q;
    logic [127:0]      ctr_q;
    logic [127:0]      data_q;

    logic [127:0]      mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;

    logic              core_ld;
    logic              core_done;
    logic [127:0]      core_in;
    logic [127:0]      core_out;
    logic              push, pop;
    logic [127:0]      result;

    aes_core u_core (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .ld_in    (core_ld),
        .key      (key_q),
        .text_in  (core_in),
        .done     (core_done),
        .text_out (core_out)
    );

    assign core_in   = mode_q ? ctr_q : in_data;
    assign result    = mode_q ? (core_out ^ data_q) : core_out;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;

    // Input is only taken when a FIFO slot is free, so the eventual push can never overflow
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        core_ld    = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: if (start) state_next = (nblocks == '0) ? FIN : LOAD;
            LOAD: begin
                in_ready = (count < (PTR_W+1)'(OUT_DEPTH));
                if (in_valid && in_ready) begin
                    core_ld    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: if (core_done) begin
                push       = 1'b1;
                state_next = (remaining == NBLK_W'(1)) ? FIN : LOAD;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            remaining <= '0;
            key_q     <= '0;
            ctr_q     <= '0;
            data_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                mode_q    <= mode;
                remaining <= nblocks;
                key_q     <= key;
                ctr_q     <= iv;
            end
            if (core_ld && mode_q) data_q <= in_data;
            // Only the low counter field advances; its carry out is dropped
            if (push) begin
                remaining <= remaining - NBLK_W'(1);
                if (mode_q) ctr_q <= (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= result;
    end

endmodule
